// File: rtl/audio_in_pkg.sv
// Shared constants for the I2S capture block: Avalon register map, STATUS/CONTROL bit positions
// and the reset value of the interrupt threshold.
package audio_in_pkg;

  localparam logic [1:0] ADDR_DATA      = 2'd0;
  localparam logic [1:0] ADDR_STATUS    = 2'd1;
  localparam logic [1:0] ADDR_CONTROL   = 2'd2;
  localparam logic [1:0] ADDR_THRESHOLD = 2'd3;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_ARMED     = 3;
  localparam int ST_LEVEL_LSB = 16;

  localparam int CTL_ENABLE = 0;
  localparam int CTL_IRQ_EN = 1;
  localparam int CTL_FLUSH  = 2;

  localparam int FIFO_DEPTH_DFLT   = 64;
  // Half of the default depth; scaled by the top when a different depth is built.
  localparam int DEFAULT_THRESHOLD = FIFO_DEPTH_DFLT / 2;

endpackage

// File: rtl/audio_in_fifo.sv
// Single-clock frame FIFO: push/pop/flush, 1-cycle registered pop data, level/full/empty from pointers.
// A push into a full FIFO is dropped (o_drop) unless a pop happens the same cycle; flush discards a same-cycle push.
module audio_in_fifo #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 64,
  parameter int LEVEL_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic [WIDTH-1:0]   i_push_dat,
  input  logic               i_pop,
  input  logic               i_flush,
  output logic [WIDTH-1:0]   o_pop_dat,
  output logic [LEVEL_W-1:0] o_level,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [LEVEL_W-1:0] r_wr_ptr;
  logic [LEVEL_W-1:0] r_rd_ptr;
  logic [WIDTH-1:0]   r_pop_dat;

  logic [LEVEL_W-1:0] w_level;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_push;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_level == LEVEL_W'(DEPTH));
  assign w_empty = (w_level == '0);
  assign w_pop   = i_pop & ~w_empty;
  assign w_push  = i_push & ~i_flush & (~w_full | w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_pop_dat <= '0;
    end else begin
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        r_wr_ptr <= r_wr_ptr + LEVEL_W'(w_push);
        r_rd_ptr <= r_rd_ptr + LEVEL_W'(w_pop);
      end
      if (w_pop) begin
        r_pop_dat <= r_mem[r_rd_ptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end
  end

  assign o_pop_dat = r_pop_dat;
  assign o_level   = w_level;
  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_drop    = i_push & ~i_flush & w_full & ~w_pop;

endmodule

// File: rtl/audio_in_i2s_receiver.sv
// I2S capture slave: synchronises codec BCLK/LRCK/DAT, frames {left,right} words into a FIFO, Avalon-MM read-out
// with read latency 1 and a registered level/overflow interrupt; frames arriving while full are dropped.
module audio_in_i2s_receiver
  import audio_in_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DFLT,
  parameter int LEVEL_W    = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        audio_in_BCLK,
  input  logic        audio_in_ADCLRCK,
  input  logic        audio_in_ADCDAT,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        irq
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [LEVEL_W-1:0] THR_RST = LEVEL_W'(DEFAULT_THRESHOLD * FIFO_DEPTH / FIFO_DEPTH_DFLT);

  logic [2:0]              r_bclk_sync;
  logic [1:0]              r_lrck_sync;
  logic [1:0]              r_dat_sync;
  logic                    r_lrck_prev;
  logic [BW-1:0]           r_bitcnt;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic [DATA_WIDTH-1:0]   r_left;
  logic                    r_armed;
  logic                    r_push;
  logic [2*DATA_WIDTH-1:0] r_push_dat;
  logic                    r_enable;
  logic                    r_irq_en;
  logic [LEVEL_W-1:0]      r_threshold;
  logic                    r_overflow;
  logic                    r_irq;
  logic [31:0]             r_readdata;
  logic                    r_rd_fifo;

  logic                    w_bclk_rise;
  logic                    w_lrck;
  logic                    w_dat;
  logic [DATA_WIDTH-1:0]   w_word;
  logic                    w_pop;
  logic                    w_flush;
  logic                    w_wr_status;
  logic                    w_wr_control;
  logic                    w_wr_thresh;
  logic [2*DATA_WIDTH-1:0] w_fifo_dat;
  logic [LEVEL_W-1:0]      w_level;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_drop;
  logic [31:0]             w_status;
  logic [31:0]             w_rd_mux;
  logic                    w_unused;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bclk_sync <= '0;
      r_lrck_sync <= '0;
      r_dat_sync  <= '0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[1:0], audio_in_BCLK};
      r_lrck_sync <= {r_lrck_sync[0], audio_in_ADCLRCK};
      r_dat_sync  <= {r_dat_sync[0], audio_in_ADCDAT};
    end
  end

  assign w_bclk_rise = r_bclk_sync[1] & ~r_bclk_sync[2];
  assign w_lrck      = r_lrck_sync[1];
  assign w_dat       = r_dat_sync[1];
  // MSB-justify whatever arrived; bits not received before an early LRCK toggle read as zero.
  assign w_word      = r_shift << (BW'(DATA_WIDTH) - r_bitcnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lrck_prev <= 1'b0;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_left      <= '0;
      r_armed     <= 1'b0;
      r_push      <= 1'b0;
      r_push_dat  <= '0;
    end else begin
      r_push <= 1'b0;
      if (w_bclk_rise) begin
        r_lrck_prev <= w_lrck;
      end
      if (!r_enable) begin
        r_bitcnt <= '0;
        r_shift  <= '0;
        r_armed  <= 1'b0;
      end else if (w_bclk_rise) begin
        if (w_lrck != r_lrck_prev) begin
          r_bitcnt <= '0;
          r_shift  <= '0;
          if (w_lrck) begin
            r_left <= w_word;
          end else begin
            r_push     <= r_armed;
            r_push_dat <= {r_left, w_word};
            r_armed    <= 1'b1;
          end
        end else if (r_bitcnt < BW'(DATA_WIDTH)) begin
          r_shift  <= {r_shift[DATA_WIDTH-2:0], w_dat};
          r_bitcnt <= r_bitcnt + BW'(1);
        end
      end
    end
  end

  assign w_pop        = avs_read & (avs_address == ADDR_DATA);
  assign w_wr_status  = avs_write & (avs_address == ADDR_STATUS);
  assign w_wr_control = avs_write & (avs_address == ADDR_CONTROL);
  assign w_wr_thresh  = avs_write & (avs_address == ADDR_THRESHOLD);
  assign w_flush      = w_wr_control & avs_writedata[CTL_FLUSH];

  audio_in_fifo #(
    .WIDTH   (2 * DATA_WIDTH),
    .DEPTH   (FIFO_DEPTH),
    .LEVEL_W (LEVEL_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (reset),
    .i_push     (r_push),
    .i_push_dat (r_push_dat),
    .i_pop      (w_pop),
    .i_flush    (w_flush),
    .o_pop_dat  (w_fifo_dat),
    .o_level    (w_level),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_drop     (w_drop)
  );

  always_comb begin
    w_status                             = '0;
    w_status[ST_EMPTY]                   = w_empty;
    w_status[ST_FULL]                    = w_full;
    w_status[ST_OVERFLOW]                = r_overflow;
    w_status[ST_ARMED]                   = r_armed;
    w_status[ST_LEVEL_LSB +: LEVEL_W]    = w_level;
  end

  always_comb begin
    w_rd_mux = '0;
    case (avs_address)
      ADDR_STATUS: w_rd_mux = w_status;
      ADDR_CONTROL: begin
        w_rd_mux[CTL_ENABLE] = r_enable;
        w_rd_mux[CTL_IRQ_EN] = r_irq_en;
      end
      ADDR_THRESHOLD: w_rd_mux[LEVEL_W-1:0] = r_threshold;
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enable    <= 1'b0;
      r_irq_en    <= 1'b0;
      r_threshold <= THR_RST;
      r_overflow  <= 1'b0;
      r_irq       <= 1'b0;
      r_readdata  <= '0;
      r_rd_fifo   <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (w_wr_status && avs_writedata[ST_OVERFLOW]) begin
        r_overflow <= 1'b0;
      end
      if (w_wr_control) begin
        r_enable <= avs_writedata[CTL_ENABLE];
        r_irq_en <= avs_writedata[CTL_IRQ_EN];
      end
      if (w_wr_thresh) begin
        r_threshold <= (avs_writedata[LEVEL_W-1:0] == '0) ? LEVEL_W'(1) : avs_writedata[LEVEL_W-1:0];
      end
      r_irq <= r_irq_en & ((w_level >= r_threshold) | r_overflow);
      // DATA reads return the FIFO's registered pop word; everything else comes from the mux.
      if (avs_read) begin
        r_rd_fifo  <= w_pop & ~w_empty;
        r_readdata <= w_rd_mux;
      end
    end
  end

  assign avs_readdata = r_rd_fifo ? 32'(w_fifo_dat) : r_readdata;
  assign irq          = r_irq;
  assign w_unused     = ^avs_writedata;

endmodule
